// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the serial pattern generator.
// The state encoding is fixed; the unused code 2'b11 is decoded as IDLE.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    localparam int         PAT_W_DEF = 4;
    localparam logic [3:0] SEQ_1011  = 4'b1011;

endpackage

// File: rtl/seq_rot_reg.sv
// Rotate-left pattern register with a parallel load port.
// It exposes the MSB the register will hold after the coming edge.
module seq_rot_reg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] load_val,
    output logic         msb_d
);

    logic [W-1:0] rot_q;
    logic [W-1:0] rot_d;

    always_comb begin
        rot_d = rot_q;
        if (load) begin
            rot_d = load_val;
        end else if (shift) begin
            rot_d = {rot_q[W-2:0], rot_q[W-1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rot_q <= '0;
        end else begin
            rot_q <= rot_d;
        end
    end

    // Output flops in the parent sample this, so xout is registered.
    assign msb_d = rot_d[W-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends a PAT_W-bit pattern MSB first, reps times
// back to back, with a start/busy/done handshake and registered outputs.
module seq_pattern_gen
    import seq_gen_pkg::*;
#(
    parameter int               PAT_W   = PAT_W_DEF,
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(SEQ_1011),
    parameter int               CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             use_def,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [CNT_W-1:0] reps,
    input  logic             abort,
    output logic             xout,
    output logic             xvalid,
    output logic             mark,
    output logic             busy,
    output logic             done
);

    localparam int              BC_W     = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [BC_W-1:0] BIT_LAST = BC_W'(PAT_W - 1);

    state_e           state_q, state_d;
    logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             load, shift, msb_d;
    logic [PAT_W-1:0] load_val;
    logic             xout_q, xout_d;
    logic             xvalid_q, xvalid_d;
    logic             mark_q, mark_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    seq_rot_reg #(.W(PAT_W)) u_rot (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift    (shift),
        .load_val (load_val),
        .msb_d    (msb_d)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rep_cnt_d = rep_cnt_q;
        load      = 1'b0;
        shift     = 1'b0;
        load_val  = use_def ? DEF_PAT : pat_in;
        case (state_q)
            ST_SHIFT: begin
                shift = 1'b1;
                // abort wins over the end-of-sequence exit
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (bit_cnt_q == '0) begin
                    bit_cnt_d = BIT_LAST;
                    rep_cnt_d = rep_cnt_q - CNT_W'(1);
                    if (rep_cnt_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - BC_W'(1);
                end
            end
            default: begin
                // IDLE, DONE and the unused code all accept start
                state_d = ST_IDLE;
                if (start) begin
                    load      = 1'b1;
                    bit_cnt_d = BIT_LAST;
                    rep_cnt_d = reps;
                    state_d   = (reps != '0) ? ST_SHIFT : ST_DONE;
                end
            end
        endcase

        // Outputs are decoded from next-state values and then registered.
        xvalid_d = (state_d == ST_SHIFT);
        busy_d   = xvalid_d;
        xout_d   = xvalid_d & msb_d;
        mark_d   = xvalid_d && (bit_cnt_d == '0);
        done_d   = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            rep_cnt_q <= '0;
            xout_q    <= 1'b0;
            xvalid_q  <= 1'b0;
            mark_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            xout_q    <= xout_d;
            xvalid_q  <= xvalid_d;
            mark_q    <= mark_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign xout   = xout_q;
    assign xvalid = xvalid_q;
    assign mark   = mark_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen: each row drives one cycle of inputs and
// queues the outputs expected in that same cycle; a monitor pops and compares.
module tb_seq_pattern_gen;

    // expected output vector bits: {xout, xvalid, mark, busy, done}
    localparam logic [4:0] E_I   = 5'b00000;
    localparam logic [4:0] E_1   = 5'b11010;
    localparam logic [4:0] E_0   = 5'b01010;
    localparam logic [4:0] E_1M  = 5'b11110;
    localparam logic [4:0] E_0M  = 5'b01110;
    localparam logic [4:0] E_D   = 5'b00001;

    logic       clk;
    logic       rst;
    logic       start;
    logic       use_def;
    logic [3:0] pat_in;
    logic [3:0] reps;
    logic       abort;
    logic       xout, xvalid, mark, busy, done;

    logic [4:0] exp_q[$];
    int         checks;
    int         errors;
    int         cyc;

    seq_pattern_gen dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .use_def (use_def),
        .pat_in  (pat_in),
        .reps    (reps),
        .abort   (abort),
        .xout    (xout),
        .xvalid  (xvalid),
        .mark    (mark),
        .busy    (busy),
        .done    (done)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // driver: apply inputs for one cycle and queue that cycle's expected outputs
    task automatic row(input logic st, input logic ud, input logic [3:0] pat,
                       input logic [3:0] rp, input logic ab, input logic rs,
                       input logic [4:0] exp_v);
        @(posedge clk);
        #1;
        start   = st;
        use_def = ud;
        pat_in  = pat;
        reps    = rp;
        abort   = ab;
        rst     = rs;
        exp_q.push_back(exp_v);
    endtask

    task automatic idle(input logic [4:0] exp_v);
        row(1'b0, 1'b0, 4'b0000, 4'd0, 1'b0, 1'b0, exp_v);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [4:0] e;
            logic [4:0] a;
            e = exp_q.pop_front();
            a = {xout, xvalid, mark, busy, done};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs cyc=%0d {xout,xvalid,mark,busy,done} got %b exp %b",
                         cyc, a, e);
            end
            cyc++;
        end
    end

    initial begin
        logic [3:0] gpat;
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        rst     = 1'b1;
        start   = 1'b0;
        use_def = 1'b0;
        pat_in  = 4'b0000;
        reps    = 4'd0;
        abort   = 1'b0;

        // reset state
        row(1'b0, 1'b0, 4'b0000, 4'd0, 1'b0, 1'b1, E_I);
        idle(E_I);

        // default pattern, one instance
        row(1'b1, 1'b1, 4'b0000, 4'd1, 1'b0, 1'b0, E_I);
        idle(E_1); idle(E_0); idle(E_1); idle(E_1M);
        idle(E_D); idle(E_I);

        // three instances with no gap, then restart from the DONE cycle
        row(1'b1, 1'b1, 4'b0000, 4'd3, 1'b0, 1'b0, E_I);
        for (int r = 0; r < 3; r++) begin
            idle(E_1); idle(E_0); idle(E_1); idle(E_1M);
        end
        row(1'b1, 1'b1, 4'b0000, 4'd1, 1'b0, 1'b0, E_D);
        idle(E_1); idle(E_0); idle(E_1); idle(E_1M);
        idle(E_D); idle(E_I);

        // custom pattern 0110 x2; start during SHIFT is ignored
        row(1'b1, 1'b0, 4'b0110, 4'd2, 1'b0, 1'b0, E_I);
        idle(E_0); idle(E_1);
        row(1'b1, 1'b1, 4'b1111, 4'd5, 1'b0, 1'b0, E_1);
        idle(E_0M); idle(E_0); idle(E_1); idle(E_1); idle(E_0M);
        idle(E_D); idle(E_I);

        // zero repetitions: done only
        row(1'b1, 1'b1, 4'b0000, 4'd0, 1'b0, 1'b0, E_I);
        idle(E_D); idle(E_I);

        // abort mid-run; later start accepted even with abort high in IDLE
        row(1'b1, 1'b1, 4'b0000, 4'd2, 1'b0, 1'b0, E_I);
        idle(E_1); idle(E_0);
        row(1'b0, 1'b0, 4'b0000, 4'd0, 1'b1, 1'b0, E_1);
        idle(E_I);
        row(1'b1, 1'b0, 4'b1001, 4'd1, 1'b1, 1'b0, E_I);
        idle(E_1); idle(E_0); idle(E_0); idle(E_1M);
        idle(E_D); idle(E_I);

        // synchronous reset mid-run
        row(1'b1, 1'b1, 4'b0000, 4'd2, 1'b0, 1'b0, E_I);
        idle(E_1);
        row(1'b0, 1'b0, 4'b0000, 4'd0, 1'b0, 1'b1, E_0);
        idle(E_I); idle(E_I);

        // maximum repetition count with pattern 1100
        gpat = 4'b1100;
        row(1'b1, 1'b0, gpat, 4'd15, 1'b0, 1'b0, E_I);
        for (int r = 0; r < 15; r++) begin
            for (int j = 0; j < 4; j++) begin
                idle({gpat[3-j], 1'b1, (j == 3), 1'b1, 1'b0});
            end
        end
        idle(E_D); idle(E_I);

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
